// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : game_pkg
//  Brief   : Shared game constants (state encodings, mole/LED mapping,
//            round length default) and a 9-bit popcount helper.
//  Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

    // Top-level game FSM encodings, shared with the hit handler
    localparam logic [1:0] INITIAL = 2'b00;
    localparam logic [1:0] GAME    = 2'b01;
    localparam logic [1:0] FINAL   = 2'b10;

    // Mole slot i is shown on LED[LED_BASE - i]
    localparam int NUM_MOLES = 9;
    localparam int LED_BASE  = 15;

    // One second of RUN at 100 MHz
    localparam logic [26:0] ROUND_CYCLES_DEFAULT = 27'd100000000;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr9.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr9
//  Brief   : 9-bit Fibonacci LFSR, taps 8 and 4, advancing on request.
//  Rev     : 1.0  initial release
// ============================================================================
module lfsr9 #(
    parameter logic [8:0] SEED = 9'h001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [8:0] q
);

    logic [8:0] r_lfsr;

    // Shift in the feedback bit only when the consumer asks for a new value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
        end
    end

    assign q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/target_generator.sv
`default_nettype none
// ============================================================================
//  Module  : target_generator
//  Brief   : Whack-a-mole target pattern and round timer. Spawns targets on
//            a periodic tick at LFSR-chosen slots, clears hit slots, and
//            closes each round with a one-cycle flush.
//  Rev     : 1.0  initial release
// ============================================================================
module target_generator
    import game_pkg::*;
#(
    parameter logic [26:0] ROUND_CYCLES = ROUND_CYCLES_DEFAULT,
    parameter int          SPAWN_PERIOD = 25000000,
    parameter int          MAX_ACTIVE   = 4,
    parameter logic [8:0]  SEED         = 9'h001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [8:0]  hit,
    output logic [15:0] LED,
    output logic [26:0] sCnt,
    output logic        round_done
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_FLUSH = 2'd2;

    localparam logic [26:0] ROUND_LAST = ROUND_CYCLES - 27'd1;
    localparam logic [26:0] SPAWN_LAST = 27'(SPAWN_PERIOD - 1);
    localparam logic [3:0]  MAX_ACT    = 4'(MAX_ACTIVE);

    logic [1:0]  r_fsm;
    logic [26:0] r_scnt;
    logic [26:0] r_spawn_cnt;
    logic [8:0]  r_slots;
    logic        r_round_done;

    logic        w_in_game;
    logic        w_round_end;
    logic        w_tick;
    logic [8:0]  w_lfsr;
    logic [3:0]  w_cand;
    logic [8:0]  w_cand_mask;
    logic [3:0]  w_popcount;
    logic        w_spawn;
    logic        w_unused_lfsr;

    assign w_in_game   = (state == GAME);
    assign w_round_end = (r_fsm == S_RUN) && (r_scnt == ROUND_LAST);
    // A tick landing on the last RUN cycle is dropped: the flush takes over
    assign w_tick      = w_in_game && (r_fsm == S_RUN) &&
                         (r_spawn_cnt == SPAWN_LAST) && !w_round_end;

    lfsr9 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (w_tick),
        .q       (w_lfsr)
    );

    assign w_cand        = w_lfsr[3:0];
    assign w_unused_lfsr = ^w_lfsr[8:4];
    // Candidates 9..15 shift the bit out of the 9-bit mask, giving no slot
    assign w_cand_mask   = 9'b1 << w_cand;
    assign w_popcount    = popcount9(r_slots);
    assign w_spawn       = w_tick && ((w_cand_mask & ~r_slots & ~hit) != 9'd0) &&
                           (w_popcount < MAX_ACT);

    // Round FSM, round timer, spawn timer and lit-slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_scnt       <= '0;
            r_spawn_cnt  <= '0;
            r_slots      <= '0;
            r_round_done <= 1'b0;
        end else if (!w_in_game) begin
            r_fsm        <= S_IDLE;
            r_scnt       <= '0;
            r_spawn_cnt  <= '0;
            r_slots      <= '0;
            r_round_done <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_fsm        <= S_RUN;
                    r_scnt       <= '0;
                    r_spawn_cnt  <= '0;
                    r_slots      <= '0;
                    r_round_done <= 1'b0;
                end
                S_RUN: begin
                    if (w_round_end) begin
                        r_fsm        <= S_FLUSH;
                        r_scnt       <= ROUND_CYCLES;
                        r_spawn_cnt  <= '0;
                        r_slots      <= '0;
                        r_round_done <= 1'b1;
                    end else begin
                        r_scnt       <= r_scnt + 27'd1;
                        r_spawn_cnt  <= (r_spawn_cnt == SPAWN_LAST) ? 27'd0
                                                                    : r_spawn_cnt + 27'd1;
                        // Hits are level-sensitive and override a same-slot spawn
                        r_slots      <= (r_slots | (w_spawn ? w_cand_mask : 9'd0)) & ~hit;
                        r_round_done <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_fsm        <= S_RUN;
                    r_scnt       <= '0;
                    r_spawn_cnt  <= '0;
                    r_slots      <= '0;
                    r_round_done <= 1'b0;
                end
                default: begin
                    r_fsm        <= S_IDLE;
                    r_scnt       <= '0;
                    r_spawn_cnt  <= '0;
                    r_slots      <= '0;
                    r_round_done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_led_map
        assign LED[LED_BASE - gi] = r_slots[gi];
    end
    assign LED[LED_BASE - NUM_MOLES:0] = '0;

    assign sCnt       = r_scnt;
    assign round_done = r_round_done;

endmodule
`default_nettype wire
